// File: rtl/floor_request_queue.sv
// Latches floor presses as pending calls and picks the next target SCAN-style.
// The next target is offered to the elevator controller over a valid/ready handshake.
module floor_request_queue #(
    parameter int unsigned NUM_FLOORS = 12,
    parameter int unsigned FLOOR_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] press,
    input  logic                  press_valid,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  arrive_valid,
    input  logic [FLOOR_W-1:0]    arrive_floor,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    input  logic                  target_ready,
    output logic                  dir_up,
    output logic                  busy,
    output logic [NUM_FLOORS-1:0] pending
);

    typedef enum logic [1:0] {IDLE, OFFER, SERVE} state_t;

    state_t                state, state_nxt;
    logic [NUM_FLOORS-1:0] pending_nxt, clr;
    logic [FLOOR_W-1:0]    target_nxt, sel_floor, cur;
    logic                  valid_nxt, dir_nxt, busy_nxt, sel_dir;
    logic [FLOOR_W-1:0]    up_lo, below_hi, dn_hi, above_lo;
    logic                  up_found, dn_found;
    logic                  arrive_at_target;

    // Out-of-range arrivals never match any bit, so they clear nothing.
    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            clr[i] = arrive_valid && (arrive_floor == FLOOR_W'(i));
        end
        pending_nxt = (pending | (press_valid ? press : '0)) & ~clr;
    end

    // SCAN candidates: nearest call ahead in each direction, and the fallback behind.
    always_comb begin
        cur = current_floor;
        if (32'(current_floor) >= NUM_FLOORS) begin
            cur = FLOOR_W'(NUM_FLOORS - 1);
        end
        up_lo    = '0;
        below_hi = '0;
        dn_hi    = '0;
        above_lo = '0;
        up_found = 1'b0;
        dn_found = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i]) begin
                if (i >= 32'(cur) && !up_found) begin
                    up_lo    = FLOOR_W'(i);
                    up_found = 1'b1;
                end
                if (i < 32'(cur)) begin
                    below_hi = FLOOR_W'(i);
                end
                if (i <= 32'(cur)) begin
                    dn_hi    = FLOOR_W'(i);
                    dn_found = 1'b1;
                end
                if (i > 32'(cur) && (above_lo == '0 || above_lo <= cur)) begin
                    above_lo = FLOOR_W'(i);
                end
            end
        end
        if (dir_up) begin
            sel_floor = up_found ? up_lo : below_hi;
            sel_dir   = up_found;
        end else begin
            sel_floor = dn_found ? dn_hi : above_lo;
            sel_dir   = !dn_found;
        end
    end

    assign arrive_at_target = arrive_valid && (arrive_floor == target_floor);

    always_comb begin
        state_nxt  = state;
        target_nxt = target_floor;
        valid_nxt  = target_valid;
        dir_nxt    = dir_up;
        busy_nxt   = busy;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    target_nxt = sel_floor;
                    dir_nxt    = sel_dir;
                    valid_nxt  = 1'b1;
                    state_nxt  = OFFER;
                end
            end
            OFFER: begin
                if (target_ready) begin
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = SERVE;
                end else if (arrive_at_target) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            SERVE: begin
                // Target already served (e.g. arrival during the handshake) also ends the trip.
                if (arrive_at_target || !pending[target_floor]) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            target_floor <= '0;
            target_valid <= 1'b0;
            dir_up       <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            pending      <= pending_nxt;
            target_floor <= target_nxt;
            target_valid <= valid_nxt;
            dir_up       <= dir_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_floor_request_queue.sv
// Directed vector bench for floor_request_queue: one table row per clock edge,
// followed by a hand-written wrap-around sequence with a bounded wait.
module tb_floor_request_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] press;
    logic        press_valid;
    logic [3:0]  current_floor;
    logic        arrive_valid;
    logic [3:0]  arrive_floor;
    logic [3:0]  target_floor;
    logic        target_valid;
    logic        target_ready;
    logic        dir_up;
    logic        busy;
    logic [11:0] pending;

    int total = 0;
    int bad   = 0;

    floor_request_queue #(.NUM_FLOORS(12), .FLOOR_W(4)) dut (
        .clk(clk), .rst(rst), .press(press), .press_valid(press_valid),
        .current_floor(current_floor), .arrive_valid(arrive_valid),
        .arrive_floor(arrive_floor), .target_floor(target_floor),
        .target_valid(target_valid), .target_ready(target_ready),
        .dir_up(dir_up), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [11:0] p;
        logic        pv;
        logic [3:0]  cf;
        logic        av;
        logic [3:0]  af;
        logic        rdy;
        logic [11:0] e_pend;
        logic        e_tv;
        logic [3:0]  e_tf;
        logic        e_du;
        logic        e_bz;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [11:0] p, input logic pv,
                                input logic [3:0] cf, input logic av, input logic [3:0] af,
                                input logic rdy, input logic [11:0] e_pend, input logic e_tv,
                                input logic [3:0] e_tf, input logic e_du, input logic e_bz);
        vec_t v;
        v.r = r; v.p = p; v.pv = pv; v.cf = cf; v.av = av; v.af = af; v.rdy = rdy;
        v.e_pend = e_pend; v.e_tv = e_tv; v.e_tf = e_tf; v.e_du = e_du; v.e_bz = e_bz;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [11:0] p, input logic pv, input logic [3:0] cf,
                         input logic av, input logic [3:0] af, input logic rdy);
        rst = r; press = p; press_valid = pv; current_floor = cf;
        arrive_valid = av; arrive_floor = af; target_ready = rdy;
    endtask

    task automatic check_all(input int idx, input vec_t v);
        check("pending", idx, 32'(pending), 32'(v.e_pend));
        check("target_valid", idx, 32'(target_valid), 32'(v.e_tv));
        check("target_floor", idx, 32'(target_floor), 32'(v.e_tf));
        check("dir_up", idx, 32'(dir_up), 32'(v.e_du));
        check("busy", idx, 32'(busy), 32'(v.e_bz));
    endtask

    initial begin
        int waited;
        drive(1'b1, 12'h000, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);

        //           r  press   pv cf  av af  rdy  pend     tv tf  du bz
        // press to offer latency, then serve floor 5
        vecs.push_back(mk(1, 12'h000, 0, 0,  0, 0,  0, 12'h000, 0, 0,  1, 0));
        vecs.push_back(mk(0, 12'h020, 1, 0,  0, 0,  0, 12'h020, 0, 0,  1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0,  0, 0,  0, 12'h020, 1, 5,  1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0,  0, 0,  1, 12'h020, 0, 5,  1, 1));
        vecs.push_back(mk(0, 12'h000, 0, 5,  1, 5,  0, 12'h000, 0, 5,  1, 0));
        // floors 2,7,10 from floor 5 going up, then wrap down to 2
        vecs.push_back(mk(0, 12'h484, 1, 5,  0, 0,  0, 12'h484, 0, 5,  1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 5,  0, 0,  0, 12'h484, 1, 7,  1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 5,  0, 0,  1, 12'h484, 0, 7,  1, 1));
        vecs.push_back(mk(0, 12'h000, 0, 7,  1, 7,  0, 12'h404, 0, 7,  1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 7,  0, 0,  0, 12'h404, 1, 10, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 7,  0, 0,  1, 12'h404, 0, 10, 1, 1));
        vecs.push_back(mk(0, 12'h000, 0, 10, 1, 10, 0, 12'h004, 0, 10, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 10, 0, 0,  0, 12'h004, 1, 2,  0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 10, 0, 0,  1, 12'h004, 0, 2,  0, 1));
        vecs.push_back(mk(0, 12'h000, 0, 2,  1, 2,  0, 12'h000, 0, 2,  0, 0));
        // offer floor 4 held without ready, then withdrawn by arrival
        vecs.push_back(mk(0, 12'h010, 1, 4,  0, 0,  0, 12'h010, 0, 2,  0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 4,  0, 0,  0, 12'h010, 1, 4,  0, 0));
        vecs.push_back(mk(0, 12'h100, 1, 4,  0, 0,  0, 12'h110, 1, 4,  0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 4,  0, 0,  0, 12'h110, 1, 4,  0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 4,  0, 0,  0, 12'h110, 1, 4,  0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 4,  0, 0,  0, 12'h110, 1, 4,  0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 4,  0, 0,  0, 12'h110, 1, 4,  0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 4,  1, 4,  0, 12'h100, 0, 4,  0, 0));
        // press+arrive same floor, out-of-range arrival, ready+arrive same edge
        vecs.push_back(mk(0, 12'h008, 1, 4,  1, 3,  0, 12'h100, 1, 8,  1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 4,  1, 13, 0, 12'h100, 1, 8,  1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 4,  1, 8,  1, 12'h000, 0, 8,  1, 1));
        vecs.push_back(mk(0, 12'h000, 0, 4,  0, 0,  0, 12'h000, 0, 8,  1, 0));
        // serve 9 while new presses accumulate
        vecs.push_back(mk(0, 12'h200, 1, 4,  0, 0,  0, 12'h200, 0, 8,  1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 4,  0, 0,  0, 12'h200, 1, 9,  1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 4,  0, 0,  1, 12'h200, 0, 9,  1, 1));
        vecs.push_back(mk(0, 12'h802, 1, 4,  0, 0,  0, 12'hA02, 0, 9,  1, 1));
        vecs.push_back(mk(0, 12'h000, 0, 4,  1, 1,  0, 12'hA00, 0, 9,  1, 1));
        vecs.push_back(mk(0, 12'h000, 0, 9,  1, 9,  0, 12'h800, 0, 9,  1, 0));
        // reset while serving with every floor pending
        vecs.push_back(mk(0, 12'hFFF, 1, 0,  0, 0,  0, 12'hFFF, 1, 11, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0,  0, 0,  1, 12'hFFF, 0, 11, 1, 1));
        vecs.push_back(mk(1, 12'hFFF, 1, 0,  0, 0,  0, 12'h000, 0, 0,  1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0,  0, 0,  0, 12'h000, 0, 0,  1, 0));
        // current_floor out of range clamps to 11
        vecs.push_back(mk(0, 12'h808, 1, 15, 0, 0,  0, 12'h808, 0, 0,  1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 15, 0, 0,  0, 12'h808, 1, 11, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].p, vecs[i].pv, vecs[i].cf,
                  vecs[i].av, vecs[i].af, vecs[i].rdy);
            @(posedge clk);
            #1;
            check_all(i, vecs[i]);
        end

        // Accept 11, arrive, then wait (bounded) for the wrap-down offer of floor 3.
        drive(1'b0, 12'h000, 1'b0, 4'd15, 1'b0, 4'd0, 1'b1);
        @(posedge clk); #1;
        check("seq_busy", 100, 32'(busy), 32'd1);
        drive(1'b0, 12'h000, 1'b0, 4'd15, 1'b1, 4'd11, 1'b0);
        @(posedge clk); #1;
        check("seq_pending", 101, 32'(pending), 32'h008);
        drive(1'b0, 12'h000, 1'b0, 4'd15, 1'b0, 4'd0, 1'b0);
        waited = 0;
        while (!target_valid && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        check("seq_offer_timeout", 102, 32'(target_valid), 32'd1);
        check("seq_wait_cycles", 103, 32'(waited), 32'd1);
        check("seq_target", 104, 32'(target_floor), 32'd3);
        check("seq_dir", 105, 32'(dir_up), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
